// File: rtl/sram_ctrl_pkg.sv
// Shared geometry defaults, FSM state encoding and response entry layout
// for the bit-write SRAM request controller.
package sram_ctrl_pkg;

  localparam int DEF_BITS       = 128;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_RESP_DEPTH = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One buffered read response; the FIFO stores it packed as {data, data1}.
  typedef struct packed {
    logic [DEF_BITS-1:0] data;
    logic [DEF_BITS-1:0] data1;
  } resp_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Small in-order response FIFO. When empty the output keeps showing the
// last entry that was popped so downstream never sees stale slot contents.
module sram_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 256,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [OCC_W-1:0] occupancy,
  output logic             empty
);

  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [W-1:0]     last_out;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign empty     = (occ == '0);
  assign occupancy = occ;
  assign do_pop    = pop && !empty;
  assign do_push   = push && ((occ != FULL_OCC) || do_pop);
  assign rdata     = empty ? last_out : mem[rd_ptr];

  // Storage array, written on push only; contents need no reset.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap at DEPTH (not necessarily a power of two); occupancy tracks push/pop.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      last_out <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
        last_out <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/sram_bw_req_ctrl.sv
// Request-side controller for the single-port bit-write SRAM macro. Zero-fills
// the array after reset, then drives the macro pins straight from accepted
// requests and queues read data (valid only the cycle after the access).
module sram_bw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [ADDR_W-1:0]   req_addr1,
  input  logic [BITS-1:0]     req_wdata,
  input  logic [BITS/8-1:0]   req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [BITS-1:0]     resp_data,
  output logic [BITS-1:0]     resp_data1,
  output logic                init_done,
  output logic                CEN,
  output logic                WEN,
  output logic [BITS-1:0]     BWEN,
  output logic [ADDR_W-1:0]   A,
  output logic [ADDR_W-1:0]   A1,
  output logic [BITS-1:0]     D,
  input  logic [BITS-1:0]     Q,
  input  logic [BITS-1:0]     Q1
);

  localparam int OCC_W = $clog2(RESP_DEPTH + 1);
  localparam logic [OCC_W:0]    RESP_LIM  = (OCC_W + 1)'(RESP_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   init_addr;
  logic                inflight;
  logic                accept;
  logic                pop;
  logic                fifo_empty;
  logic [OCC_W-1:0]    occ;
  logic [OCC_W:0]      pending;
  logic [BITS-1:0]     strb_mask;
  logic [2*BITS-1:0]   fifo_rdata;

  // Slots committed once this cycle settles: buffered + the read whose data
  // arrives now, minus the entry leaving now. Never negative since pop implies occ>0.
  assign pop        = resp_valid && resp_ready;
  assign pending    = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
  assign req_ready  = (state == RUN) && (pending < RESP_LIM);
  assign accept     = req_valid && req_ready;
  assign init_done  = (state == RUN);
  assign resp_valid = !fifo_empty;
  assign resp_data  = fifo_rdata[2*BITS-1:BITS];
  assign resp_data1 = fifo_rdata[BITS-1:0];

  // Expand byte strobes to one enable bit per data bit.
  always_comb begin
    strb_mask = '0;
    for (int i = 0; i < BITS; i++) begin
      strb_mask[i] = req_wstrb[i/8];
    end
  end

  // State register, zero-fill address counter and the one-cycle read-in-flight flag.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= INIT;
      init_addr <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= accept && !req_write;
      if (state == INIT) begin
        init_addr <= init_addr + ADDR_W'(1);
      end
    end
  end

  // Next state and macro pin mux: zero-fill writes in INIT, request pass-through in RUN.
  always_comb begin
    state_nxt = state;
    CEN       = 1'b1;
    WEN       = 1'b1;
    BWEN      = '1;
    A         = '0;
    A1        = '0;
    D         = '0;
    case (state)
      INIT: begin
        CEN  = 1'b0;
        WEN  = 1'b0;
        BWEN = '0;
        A    = init_addr;
        if (init_addr == LAST_ADDR) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          CEN = 1'b0;
          A   = req_addr;
          if (req_write) begin
            WEN  = 1'b0;
            D    = req_wdata;
            BWEN = ~strb_mask;
          end else begin
            A1 = req_addr1;
          end
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  sram_resp_fifo #(
    .DEPTH(RESP_DEPTH),
    .W    (2*BITS)
  ) u_resp_fifo (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .push     (inflight),
    .pop      (pop),
    .wdata    ({Q, Q1}),
    .rdata    (fifo_rdata),
    .occupancy(occ),
    .empty    (fifo_empty)
  );

endmodule
